// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and holds results for a fixed
// latency before committing them, reporting busy while an operation is in flight.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  MDUcon,
    output logic        busy,
    output logic [31:0] MDUout
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e         state, next_state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi, lo, tmp_hi, tmp_lo;

    logic           start_mul, start_div;
    logic           mul_signed, div_signed;
    logic [63:0]    mul_a, mul_b, prod;
    logic           a_neg, b_neg;
    logic [31:0]    a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign start_mul  = (state == S_IDLE) && (MDUcon == OP_MULT || MDUcon == OP_MULTU);
    assign start_div  = (state == S_IDLE) && (MDUcon == OP_DIV  || MDUcon == OP_DIVU);
    assign mul_signed = (MDUcon == OP_MULT);
    assign div_signed = (MDUcon == OP_DIV);

    // Sign-extending to 64 bits makes the low 64 bits of one multiplier correct for both flavours.
    assign mul_a = {{32{mul_signed & in1[31]}}, in1};
    assign mul_b = {{32{mul_signed & in2[31]}}, in2};
    assign prod  = mul_a * mul_b;

    // Signed divide through magnitudes: avoids the 0x80000000 / -1 overflow corner
    // and gives truncation toward zero with the remainder following the dividend.
    assign a_neg = div_signed & in1[31];
    assign b_neg = div_signed & in2[31];
    assign a_mag = a_neg ? -in1 : in1;
    assign b_mag = (in2 == '0) ? 32'd1 : (b_neg ? -in2 : in2);
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    next_state = S_MUL;
                end else if (start_div) begin
                    next_state = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == '0) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            cnt    <= '0;
        end else if (state == S_IDLE) begin
            if (start_mul) begin
                {tmp_hi, tmp_lo} <= prod;
                cnt              <= CW'(MULT_CYCLES - 1);
            end else if (start_div) begin
                // Divide by zero stages the current HI/LO so the commit is a no-op.
                if (in2 == '0) begin
                    tmp_hi <= hi;
                    tmp_lo <= lo;
                end else begin
                    tmp_hi <= rem;
                    tmp_lo <= quot;
                end
                cnt <= CW'(DIV_CYCLES - 1);
            end else if (MDUcon == OP_MTHI) begin
                hi <= in1;
            end else if (MDUcon == OP_MTLO) begin
                lo <= in1;
            end
        end else begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                hi <= tmp_hi;
                lo <= tmp_lo;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        MDUout = '0;
        if (MDUcon == OP_MFHI) begin
            MDUout = hi;
        end else if (MDUcon == OP_MFLO) begin
            MDUout = lo;
        end
    end

endmodule
